multiplier_buffered: RTL and testbench

MULTIPLIER_BUFFERED -- requirements
Module: multiplier_buffered

---
 rtl/multiplier_buffered_if.sv | 39 +++
 rtl/multiplier_buffered.sv | 144 ++++++++++++++
 tb/tb_multiplier_buffered.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_buffered_if.sv
// Operand, memory-write, memory-read and status bundle of multiplier_buffered.
// The master side drives operands, block-read requests and external read data.
interface multiplier_buffered_if #(
   parameter int IN_W  = 16,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 2 * IN_W;

   logic            EN_mult;
   logic            mode_signed;
   logic [IN_W-1:0] mult_input0;
   logic [IN_W-1:0] mult_input1;
   logic            EN_blockRead;
   logic [PW-1:0]   readMem_val;

   logic            RDY_mult;
   logic            EN_writeMem;
   logic [AW-1:0]   writeMem_addr;
   logic [PW-1:0]   writeMem_val;
   logic            EN_readMem;
   logic [AW-1:0]   readMem_addr;
   logic            VALID_memVal;
   logic [PW-1:0]   memVal_data;
   logic [AW:0]     mem_count;
   logic            overflow;

   modport master (
      output EN_mult, mode_signed, mult_input0, mult_input1, EN_blockRead, readMem_val,
      input  RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
      input  readMem_addr, VALID_memVal, memVal_data, mem_count, overflow
   );

   modport slave (
      input  EN_mult, mode_signed, mult_input0, mult_input1, EN_blockRead, readMem_val,
      output RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
      output readMem_addr, VALID_memVal, memVal_data, mem_count, overflow
   );
endinterface

// File: rtl/multiplier_buffered.sv
// Pipelined multiplier filling an external buffer, then block-reading it back; write lands PIPE
// cycles after accept, RDY_mult drops once buffered+in-flight products would reach DEPTH.
module multiplier_buffered #(
   parameter int IN_W  = 16,
   parameter int DEPTH = 64,
   parameter int PIPE  = 2
) (
   input  logic                clk,
   input  logic                rst,
   multiplier_buffered_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 2 * IN_W;
   localparam int CW = AW + 2;

   typedef enum logic [1:0] {IDLE_WRITE, DRAIN, FULL, READ} state_e;

   state_e        state_q, state_d;
   logic [PIPE-1:0] vld_q;
   logic [PW-1:0] dat_q [PIPE];
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_vld_q;
   logic          ovf_q;

   logic [CW-1:0] inflight;
   logic [CW-1:0] committed;
   logic          rdy;
   logic          accept;
   logic          wr;
   logic          last_read;
   logic [PW-1:0] a_ext, b_ext, prod;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE; i++) begin
         inflight = inflight + CW'(vld_q[i]);
      end
      committed = CW'(count_q) + inflight;
      rdy       = !rst && (state_q == IDLE_WRITE) && (committed < CW'(DEPTH));
      accept    = bus.EN_mult && rdy;
      wr        = vld_q[PIPE-1];
      last_read = ({1'b0, rd_addr_q} == (count_q - (AW+1)'(1)));
   end

   // Extend both operands to the full product width so a single PW-bit multiply
   // yields the correct low PW bits for either signedness.
   always_comb begin
      a_ext = bus.mode_signed ? {{IN_W{bus.mult_input0[IN_W-1]}}, bus.mult_input0}
                              : {{IN_W{1'b0}}, bus.mult_input0};
      b_ext = bus.mode_signed ? {{IN_W{bus.mult_input1[IN_W-1]}}, bus.mult_input1}
                              : {{IN_W{1'b0}}, bus.mult_input1};
      prod  = a_ext * b_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= accept;
         for (int i = 1; i < PIPE; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         dat_q[0] <= prod;
      end
      for (int i = 1; i < PIPE; i++) begin
         dat_q[i] <= dat_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE_WRITE;
      end else begin
         state_q <= state_d;
      end
   end

   // A block-read accepted together with an operand still counts that product.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE_WRITE: begin
            if (bus.EN_blockRead && ((committed != '0) || accept)) begin
               state_d = DRAIN;
            end else if ((count_q == (AW+1)'(DEPTH)) && (inflight == '0)) begin
               state_d = FULL;
            end
         end
         DRAIN:   if (inflight == '0) state_d = READ;
         FULL:    if (bus.EN_blockRead) state_d = READ;
         READ:    if (last_read) state_d = IDLE_WRITE;
         default: state_d = IDLE_WRITE;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      rd_addr_d = rd_addr_q;
      if (wr) begin
         count_d = count_q + (AW+1)'(1);
      end
      if (state_q == READ) begin
         if (last_read) begin
            count_d   = '0;
            rd_addr_d = '0;
         end else begin
            rd_addr_d = rd_addr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         rd_addr_q <= '0;
         rd_vld_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         rd_addr_q <= rd_addr_d;
         rd_vld_q  <= (state_q == READ);
         ovf_q     <= bus.EN_mult && !rdy;
      end
   end

   always_comb begin
      bus.RDY_mult      = rdy;
      bus.EN_writeMem   = wr;
      bus.writeMem_addr = count_q[AW-1:0];
      bus.writeMem_val  = wr ? dat_q[PIPE-1] : '0;
      bus.EN_readMem    = (state_q == READ);
      bus.readMem_addr  = rd_addr_q;
      bus.VALID_memVal  = rd_vld_q;
      bus.memVal_data   = bus.readMem_val;
      bus.mem_count     = count_q;
      bus.overflow      = ovf_q;
   end
endmodule

// File: tb/tb_multiplier_buffered.sv
// Bench for multiplier_buffered with a one-cycle-latency external memory and a
// queue-based product/address reference model.
module tb_multiplier_buffered;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multiplier_buffered_if #(.IN_W(16), .DEPTH(64)) bus();

   multiplier_buffered #(.IN_W(16), .DEPTH(64), .PIPE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] ext_mem [64];
   logic [31:0] rd_q;
   assign bus.readMem_val = rd_q;
   always @(posedge clk) begin
      if (bus.EN_writeMem) ext_mem[bus.writeMem_addr] <= bus.writeMem_val;
      if (bus.EN_readMem)  rd_q <= ext_mem[bus.readMem_addr];
   end

   typedef struct { int due; logic [31:0] val; } wr_t;
   wr_t         expq[$];
   logic [31:0] model_mem [64];
   int          model_count = 0;
   int          accepted = 0;
   bit          prev_rej = 0;
   int          cyc = 0;
   int          chk_cnt = 0;
   int          pass_cnt = 0;

   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input bit sgn);
      longint x, y, p;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'(a);
         y = longint'(b);
      end
      p = x * y;
      return p[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_accepts(input int n, input int pct, input bit blk_last, input bit hold);
      int acc = 0;
      int guard = 0;
      bit draining = 0;
      bit exp_rdy, exp_wr, en, s;
      logic [15:0] a, b;
      while ((acc < n || expq.size() > 0) && guard < 500) begin
         exp_rdy = !draining && (accepted < 64);
         exp_wr  = (expq.size() > 0) && (expq[0].due == cyc);
         chk_cnt++;
         if (bus.RDY_mult !== exp_rdy) $display("FAIL rdy cyc=%0d got %b exp %b", cyc, bus.RDY_mult, exp_rdy);
         else pass_cnt++;
         chk_cnt++;
         if (bus.overflow !== prev_rej) $display("FAIL overflow cyc=%0d got %b exp %b", cyc, bus.overflow, prev_rej);
         else pass_cnt++;
         chk_cnt++;
         if (bus.mem_count !== 7'(model_count)) $display("FAIL mem_count cyc=%0d got %0d exp %0d", cyc, bus.mem_count, model_count);
         else pass_cnt++;
         chk_cnt++;
         if (bus.EN_writeMem !== exp_wr) $display("FAIL en_write cyc=%0d got %b exp %b", cyc, bus.EN_writeMem, exp_wr);
         else pass_cnt++;
         if (exp_wr) begin
            chk_cnt++;
            if (bus.writeMem_addr !== 6'(model_count)) $display("FAIL wr_addr got %0d exp %0d", bus.writeMem_addr, model_count);
            else pass_cnt++;
            chk_cnt++;
            if (bus.writeMem_val !== expq[0].val) $display("FAIL wr_val got %h exp %h", bus.writeMem_val, expq[0].val);
            else pass_cnt++;
            model_mem[model_count] = expq[0].val;
            model_count++;
            void'(expq.pop_front());
         end
         en = (acc < n) ? ($urandom_range(99) < pct) : hold;
         a  = 16'($urandom);
         b  = 16'($urandom);
         s  = 1'($urandom_range(1));
         bus.EN_mult     = en;
         bus.mult_input0 = a;
         bus.mult_input1 = b;
         bus.mode_signed = s;
         if (en && exp_rdy) begin
            expq.push_back('{due: cyc + 2, val: ref_prod(a, b, s)});
            acc++;
            accepted++;
         end
         bus.EN_blockRead = blk_last && en && exp_rdy && (acc == n);
         if (bus.EN_blockRead) draining = 1;
         prev_rej = en && !exp_rdy;
         tick();
         guard++;
      end
      bus.EN_mult      = 1'b0;
      bus.EN_blockRead = 1'b0;
      chk_cnt++;
      if (guard >= 500) $display("FAIL write_phase_timeout acc=%0d exp %0d", acc, n);
      else pass_cnt++;
   endtask

   task automatic read_phase(input int n);
      int waitc = 0;
      while (bus.EN_readMem !== 1'b1 && waitc < 6) begin
         chk_cnt++;
         if (bus.RDY_mult !== 1'b0) $display("FAIL rdy_before_read got %b exp 0", bus.RDY_mult);
         else pass_cnt++;
         tick();
         waitc++;
      end
      chk_cnt++;
      if (bus.EN_readMem !== 1'b1) begin
         $display("FAIL read_start_timeout got %b exp 1", bus.EN_readMem);
         return;
      end
      pass_cnt++;
      for (int i = 0; i < n; i++) begin
         chk_cnt++;
         if (bus.EN_readMem !== 1'b1 || bus.readMem_addr !== 6'(i))
            $display("FAIL read_addr i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, bus.EN_readMem, bus.readMem_addr, i);
         else pass_cnt++;
         chk_cnt++;
         if (bus.VALID_memVal !== (i > 0)) $display("FAIL valid_lag i=%0d got %b exp %b", i, bus.VALID_memVal, (i > 0));
         else pass_cnt++;
         if (i > 0) begin
            chk_cnt++;
            if (bus.memVal_data !== model_mem[i-1]) $display("FAIL read_data i=%0d got %h exp %h", i-1, bus.memVal_data, model_mem[i-1]);
            else pass_cnt++;
         end
         bus.EN_blockRead = (i == 1);
         tick();
      end
      bus.EN_blockRead = 1'b0;
      chk_cnt++;
      if (bus.EN_readMem !== 1'b0 || bus.VALID_memVal !== 1'b1)
         $display("FAIL read_end got en=%b valid=%b exp en=0 valid=1", bus.EN_readMem, bus.VALID_memVal);
      else pass_cnt++;
      chk_cnt++;
      if (bus.memVal_data !== model_mem[n-1]) $display("FAIL read_last_data got %h exp %h", bus.memVal_data, model_mem[n-1]);
      else pass_cnt++;
      chk_cnt++;
      if (bus.RDY_mult !== 1'b1 || bus.mem_count !== 7'd0)
         $display("FAIL after_read got rdy=%b count=%0d exp rdy=1 count=0", bus.RDY_mult, bus.mem_count);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.VALID_memVal !== 1'b0) $display("FAIL valid_end got %b exp 0", bus.VALID_memVal);
      else pass_cnt++;
      model_count = 0;
      accepted    = 0;
      prev_rej    = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.EN_mult = 0; bus.mode_signed = 0; bus.mult_input0 = 0; bus.mult_input1 = 0; bus.EN_blockRead = 0;
      repeat (3) tick();
      chk_cnt++;
      if ({bus.RDY_mult, bus.EN_writeMem, bus.EN_readMem, bus.VALID_memVal, bus.overflow} !== 5'b0)
         $display("FAIL reset_ctrl got %b exp 00000", {bus.RDY_mult, bus.EN_writeMem, bus.EN_readMem, bus.VALID_memVal, bus.overflow});
      else pass_cnt++;
      chk_cnt++;
      if (bus.mem_count !== 7'd0 || bus.writeMem_addr !== 6'd0 || bus.readMem_addr !== 6'd0 || bus.writeMem_val !== 32'd0)
         $display("FAIL reset_data got count=%0d wa=%0d ra=%0d wv=%h exp 0", bus.mem_count, bus.writeMem_addr, bus.readMem_addr, bus.writeMem_val);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      chk_cnt++;
      if (bus.RDY_mult !== 1'b1) $display("FAIL rdy_after_reset got %b exp 1", bus.RDY_mult);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      bus.EN_mult = 1; bus.mult_input0 = 16'h0003; bus.mult_input1 = 16'h0005; bus.mode_signed = 0;
      tick();
      bus.EN_mult = 0;
      chk_cnt++;
      if (bus.EN_writeMem !== 1'b0) $display("FAIL basic_early_write got %b exp 0", bus.EN_writeMem);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.EN_writeMem !== 1'b1 || bus.writeMem_addr !== 6'd0 || bus.writeMem_val !== 32'h0000000F)
         $display("FAIL basic_write got en=%b addr=%0d val=%h exp en=1 addr=0 val=0000000f", bus.EN_writeMem, bus.writeMem_addr, bus.writeMem_val);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.mem_count !== 7'd1) $display("FAIL basic_count got %0d exp 1", bus.mem_count);
      else pass_cnt++;
      model_mem[0] = ref_prod(16'h0003, 16'h0005, 1'b0);
      model_count = 1; accepted = 1;
   endtask

   task automatic test_signed();
      bus.EN_mult = 1; bus.mult_input0 = 16'hFFFF; bus.mult_input1 = 16'h0002; bus.mode_signed = 1;
      tick();
      bus.mode_signed = 0;
      tick();
      bus.EN_mult = 0;
      chk_cnt++;
      if (bus.EN_writeMem !== 1'b1 || bus.writeMem_addr !== 6'd1 || bus.writeMem_val !== 32'hFFFFFFFE)
         $display("FAIL signed_mul got en=%b addr=%0d val=%h exp en=1 addr=1 val=fffffffe", bus.EN_writeMem, bus.writeMem_addr, bus.writeMem_val);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.EN_writeMem !== 1'b1 || bus.writeMem_addr !== 6'd2 || bus.writeMem_val !== 32'h0001FFFE)
         $display("FAIL unsigned_mul got en=%b addr=%0d val=%h exp en=1 addr=2 val=0001fffe", bus.EN_writeMem, bus.writeMem_addr, bus.writeMem_val);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.mem_count !== 7'd3) $display("FAIL signed_count got %0d exp 3", bus.mem_count);
      else pass_cnt++;
      model_mem[1] = ref_prod(16'hFFFF, 16'h0002, 1'b1);
      model_mem[2] = ref_prod(16'hFFFF, 16'h0002, 1'b0);
      model_count = 3; accepted = 3;
      bus.EN_blockRead = 1;
      tick();
      bus.EN_blockRead = 0;
      read_phase(3);
   endtask

   task automatic test_empty_read();
      bus.EN_blockRead = 1;
      tick();
      bus.EN_blockRead = 0;
      for (int k = 0; k < 4; k++) begin
         chk_cnt++;
         if (bus.EN_readMem !== 1'b0 || bus.RDY_mult !== 1'b1)
            $display("FAIL empty_read k=%0d got en_read=%b rdy=%b exp 0/1", k, bus.EN_readMem, bus.RDY_mult);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_fill_full();
      drive_accepts(64, 100, 0, 1);
      for (int k = 0; k < 5; k++) begin
         chk_cnt++;
         if (bus.overflow !== prev_rej) $display("FAIL full_overflow k=%0d got %b exp %b", k, bus.overflow, prev_rej);
         else pass_cnt++;
         prev_rej = 0;
         chk_cnt++;
         if (bus.RDY_mult !== 1'b0 || bus.EN_readMem !== 1'b0 || bus.mem_count !== 7'd64)
            $display("FAIL full_hold k=%0d got rdy=%b en_read=%b count=%0d exp 0/0/64", k, bus.RDY_mult, bus.EN_readMem, bus.mem_count);
         else pass_cnt++;
         tick();
      end
      bus.EN_blockRead = 1;
      tick();
      bus.EN_blockRead = 0;
      chk_cnt++;
      if (bus.EN_readMem !== 1'b1) $display("FAIL full_to_read got %b exp 1", bus.EN_readMem);
      else pass_cnt++;
      read_phase(64);
   endtask

   task automatic test_partial_read();
      drive_accepts(5, 100, 1, 0);
      read_phase(5);
      for (int r = 0; r < 3; r++) begin
         int n = $urandom_range(1, 40);
         drive_accepts(n, 60, 1, 0);
         read_phase(n);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      drive_accepts(20, 80, 1, 0);
      while ((bus.EN_readMem !== 1'b1 || bus.readMem_addr !== 6'd10) && guard < 30) begin
         tick();
         guard++;
      end
      chk_cnt++;
      if (bus.readMem_addr !== 6'd10 || bus.EN_readMem !== 1'b1)
         $display("FAIL mid_read_reach got en=%b addr=%0d exp en=1 addr=10", bus.EN_readMem, bus.readMem_addr);
      else pass_cnt++;
      rst = 1;
      tick();
      chk_cnt++;
      if (bus.EN_readMem !== 1'b0 || bus.mem_count !== 7'd0 || bus.RDY_mult !== 1'b0 || bus.VALID_memVal !== 1'b0)
         $display("FAIL mid_reset got en_read=%b count=%0d rdy=%b valid=%b exp all 0", bus.EN_readMem, bus.mem_count, bus.RDY_mult, bus.VALID_memVal);
      else pass_cnt++;
      rst = 0;
      #1;
      chk_cnt++;
      if (bus.RDY_mult !== 1'b1) $display("FAIL mid_release_rdy got %b exp 1", bus.RDY_mult);
      else pass_cnt++;
      model_count = 0; accepted = 0; prev_rej = 0; expq.delete();
      bus.EN_mult = 1; bus.mult_input0 = 16'h1234; bus.mult_input1 = 16'h0101;
      tick();
      bus.EN_mult = 0;
      rst = 1;
      tick();
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         chk_cnt++;
         if (bus.EN_writeMem !== 1'b0) $display("FAIL inflight_discard k=%0d got %b exp 0", k, bus.EN_writeMem);
         else pass_cnt++;
         tick();
      end
      drive_accepts(1, 100, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_empty_read();
      test_fill_full();
      test_partial_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
